// File: rtl/team_06_pkg.sv
// Shared types and constants for the receive-path sample FIFO.
package team_06_pkg;

  typedef logic signed [7:0] sample_t;

  typedef enum logic {FILL, PLAY} fifo_state_t;

  localparam logic [7:0] SAT_MAX = 8'd255;

endpackage

// File: rtl/team_06_sat_counter.sv
// 8-bit event counter that sticks at SAT_MAX instead of wrapping.
module team_06_sat_counter
  import team_06_pkg::*;
(
  input  logic       clk_i,
  input  logic       clear_i,
  input  logic       inc_i,
  output logic [7:0] count_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != SAT_MAX)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/team_06_rx_sample_fifo.sv
// Elastic sample buffer between the ESP deserializer and the volume shifter:
// prefills before playback, returns SILENCE on underflow, drops on overflow.
module team_06_rx_sample_fifo
  import team_06_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PREFILL = 8,
  parameter sample_t     SILENCE = 8'sd0
) (
  input  logic                     hwclk,
  input  logic                     reset,
  input  sample_t                  sample_in,
  input  logic                     sample_valid,
  input  logic                     read_req,
  input  logic                     flush,
  output sample_t                  sample_out,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     playing,
  output logic [7:0]               overflow_cnt,
  output logic [7:0]               underflow_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DepthLvl   = LW'(DEPTH);
  localparam logic [LW-1:0] PrefillLvl = LW'(PREFILL);

  sample_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  fifo_state_t     state_q, state_d;
  sample_t         sample_out_q, sample_out_d;
  logic            out_valid_q, out_valid_d;
  logic            full, empty, push, pop, underflow, overflow;

  // All full/empty decisions use the pre-cycle level; a read may free the
  // slot a same-cycle write lands in, since mem is read before the edge.
  always_comb begin
    full      = (level_q == DepthLvl);
    empty     = (level_q == '0);
    pop       = !flush && read_req && (state_q == PLAY) && !empty;
    underflow = !flush && read_req && (state_q == PLAY) && empty;
    push      = !flush && sample_valid && (!full || pop);
    overflow  = !flush && sample_valid && !push;
  end

  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end

    state_d = state_q;
    if (flush) begin
      state_d = FILL;
    end else begin
      unique case (state_q)
        FILL: if (level_d >= PrefillLvl) state_d = PLAY;
        PLAY: if (underflow) state_d = FILL;
        default: state_d = FILL;
      endcase
    end

    out_valid_d  = !flush && read_req;
    sample_out_d = sample_out_q;
    if (flush) begin
      sample_out_d = SILENCE;
    end else if (read_req) begin
      sample_out_d = pop ? mem_q[rd_ptr_q] : SILENCE;
    end
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      state_q      <= FILL;
      sample_out_q <= SILENCE;
      out_valid_q  <= 1'b0;
    end else begin
      level_q      <= level_d;
      state_q      <= state_d;
      sample_out_q <= sample_out_d;
      out_valid_q  <= out_valid_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge hwclk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  team_06_sat_counter u_overflow_cnt (
    .clk_i   (hwclk),
    .clear_i (reset),
    .inc_i   (overflow),
    .count_o (overflow_cnt)
  );

  team_06_sat_counter u_underflow_cnt (
    .clk_i   (hwclk),
    .clear_i (reset),
    .inc_i   (underflow),
    .count_o (underflow_cnt)
  );

  assign sample_out = sample_out_q;
  assign out_valid  = out_valid_q;
  assign level      = level_q;
  assign playing    = (state_q == PLAY);

endmodule

// File: tb/tb_team_06_rx_sample_fifo.sv
// Directed bench for the receive sample FIFO with a queue scoreboard for streaming.
module tb_team_06_rx_sample_fifo;

  logic       hwclk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic       read_req = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] sample_out;
  logic       out_valid;
  logic [4:0] level;
  logic       playing;
  logic [7:0] overflow_cnt;
  logic [7:0] underflow_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  sb [$];
  logic [7:0]  exp_v;

  team_06_rx_sample_fifo dut (
    .hwclk         (hwclk),
    .reset         (reset),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .read_req      (read_req),
    .flush         (flush),
    .sample_out    (sample_out),
    .out_valid     (out_valid),
    .level         (level),
    .playing       (playing),
    .overflow_cnt  (overflow_cnt),
    .underflow_cnt (underflow_cnt)
  );

  always #5 hwclk = ~hwclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge hwclk);
    #1;
  endtask

  task automatic wr(input logic [7:0] v);
    sample_valid = 1'b1;
    sample_in    = v;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, sample_out}, {24'd0, exp});
  endtask

  task automatic wr_rd(input string tag, input logic [7:0] v, input logic [7:0] exp);
    sample_valid = 1'b1;
    sample_in    = v;
    read_req     = 1'b1;
    tick();
    sample_valid = 1'b0;
    read_req     = 1'b0;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, sample_out}, {24'd0, exp});
  endtask

  initial begin
    // Reset
    tick();
    tick();
    reset = 1'b0;
    check("rst_out", {24'd0, sample_out}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_level", {27'd0, level}, 32'd0);
    check("rst_playing", {31'd0, playing}, 32'd0);
    check("rst_ovf", {24'd0, overflow_cnt}, 32'd0);
    check("rst_unf", {24'd0, underflow_cnt}, 32'd0);

    // Prefill
    for (int i = 1; i <= 7; i++) wr(8'(i));
    check("pf_playing7", {31'd0, playing}, 32'd0);
    check("pf_level7", {27'd0, level}, 32'd7);
    rd("pf_fill_read", 8'h00);
    check("pf_unf", {24'd0, underflow_cnt}, 32'd0);
    check("pf_level_keep", {27'd0, level}, 32'd7);
    wr(8'h08);
    check("pf_playing8", {31'd0, playing}, 32'd1);
    check("pf_level8", {27'd0, level}, 32'd8);
    for (int i = 1; i <= 4; i++) rd("pf_read", 8'(i));
    tick();
    check("pf_valid_pulse", {31'd0, out_valid}, 32'd0);
    check("pf_out_hold", {24'd0, sample_out}, 32'd4);

    // Underflow
    for (int i = 5; i <= 7; i++) rd("uf_drain", 8'(i));
    check("uf_level1", {27'd0, level}, 32'd1);
    rd("uf_last", 8'h08);
    check("uf_playing_before", {31'd0, playing}, 32'd1);
    rd("uf_silence", 8'h00);
    check("uf_cnt", {24'd0, underflow_cnt}, 32'd1);
    check("uf_playing", {31'd0, playing}, 32'd0);
    check("uf_level0", {27'd0, level}, 32'd0);

    // Overflow
    for (int i = 0; i < 20; i++) wr(8'(8'h40 + i));
    check("of_level", {27'd0, level}, 32'd16);
    check("of_cnt", {24'd0, overflow_cnt}, 32'd4);
    check("of_playing", {31'd0, playing}, 32'd1);

    // Simultaneous read and write while full
    wr_rd("sim_full", 8'h99, 8'h40);
    check("sim_full_level", {27'd0, level}, 32'd16);
    check("sim_full_ovf", {24'd0, overflow_cnt}, 32'd4);
    for (int i = 1; i < 16; i++) rd("of_read", 8'(8'h40 + i));
    rd("sim_full_tail", 8'h99);
    check("of_empty_level", {27'd0, level}, 32'd0);
    check("of_empty_playing", {31'd0, playing}, 32'd1);

    // Simultaneous read and write while empty
    wr_rd("sim_empty", 8'h55, 8'h00);
    check("sim_empty_level", {27'd0, level}, 32'd1);
    check("sim_empty_playing", {31'd0, playing}, 32'd0);
    check("sim_empty_unf", {24'd0, underflow_cnt}, 32'd2);

    // Wrap-around streaming
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("wr_flush_level", {27'd0, level}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      wr(8'(i * 37 + 5));
      sb.push_back(8'(i * 37 + 5));
    end
    check("wr_playing", {31'd0, playing}, 32'd1);
    for (int i = 10; i < 100; i++) begin
      exp_v = sb.pop_front();
      sb.push_back(8'(i * 37 + 5));
      if (i % 3 == 0) begin
        rd("wr_read", exp_v);
        wr(8'(i * 37 + 5));
      end else begin
        wr_rd("wr_stream", 8'(i * 37 + 5), exp_v);
      end
      if ((level < 5'd4) || (level > 5'd12)) check("wr_level_range", {27'd0, level}, 32'd10);
    end
    for (int i = 0; i < 10; i++) begin
      exp_v = sb.pop_front();
      rd("wr_drain", exp_v);
    end
    check("wr_ovf", {24'd0, overflow_cnt}, 32'd4);
    check("wr_unf", {24'd0, underflow_cnt}, 32'd2);
    check("wr_end_level", {27'd0, level}, 32'd0);

    // Flush mid-PLAY, colliding with a read and a write
    for (int i = 0; i < 9; i++) wr(8'(8'h70 + i));
    check("fl_playing_before", {31'd0, playing}, 32'd1);
    flush        = 1'b1;
    read_req     = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 8'hEE;
    tick();
    flush        = 1'b0;
    read_req     = 1'b0;
    sample_valid = 1'b0;
    check("fl_level", {27'd0, level}, 32'd0);
    check("fl_playing", {31'd0, playing}, 32'd0);
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_out", {24'd0, sample_out}, 32'd0);
    check("fl_ovf", {24'd0, overflow_cnt}, 32'd4);
    check("fl_unf", {24'd0, underflow_cnt}, 32'd2);
    wr(8'h21);
    for (int i = 0; i < 7; i++) wr(8'h00);
    rd("fl_restart", 8'h21);

    // Saturation
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 316; i++) wr(8'(i));
    check("sat_level", {27'd0, level}, 32'd16);
    check("sat_ovf", {24'd0, overflow_cnt}, 32'd255);

    // Reset clears counters
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_ovf", {24'd0, overflow_cnt}, 32'd0);
    check("rst2_unf", {24'd0, underflow_cnt}, 32'd0);
    check("rst2_level", {27'd0, level}, 32'd0);
    check("rst2_playing", {31'd0, playing}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/team_06_rx_sample_fifo.md
# team_06_rx_sample_fifo

Elastic sample buffer on the receive path. It sits between the ESP-to-SPI deserializer and the volume shifter, and absorbs rate jitter between ESP32 sample arrival and the I2S DAC word clock. It prefills before playback, outputs silence on underflow, drops samples on overflow, and keeps saturating error counters for the display and debug.

## Interface
Parameters:
- DEPTH, 16, number of 8-bit sample entries; must be a power of two, at least 4.
- PREFILL, 8, number of stored samples required to leave FILL; range 1 to DEPTH.
- SILENCE, 8'sd0, value driven on underflow or while filling (signed; DAC stage adds 128).

Ports (clock and reset first):
- hwclk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- sample_in  input  8  signed sample from the ESP deserializer.
- sample_valid  input  1  one-cycle pulse; sample_in is valid in that cycle.
- read_req  input  1  one-cycle pulse from the DAC side requesting the next sample.
- flush  input  1  synchronous clear of stored data; counters are retained.
- sample_out  output  8  registered sample presented to the volume shifter.
- out_valid  output  1  one-cycle pulse, asserted the cycle after read_req.
- level  output  $clog2(DEPTH)+1  current occupancy, 0 to DEPTH.
- playing  output  1  high in the PLAY state.
- overflow_cnt  output  8  saturating count of dropped writes.
- underflow_cnt  output  8  saturating count of reads served with SILENCE.

## Operation
- Storage: DEPTH×8 register array, with wr_ptr and rd_ptr of $clog2(DEPTH) bits each. Both pointers wrap modulo DEPTH. level is a separate counter.
- States:
  - FILL (reset state). Writes are accepted and reads return SILENCE. Reads in FILL are not counted as underflow. Transition to PLAY when, after this cycle's update, level ≥ PREFILL.
  - PLAY. On read_req with pre-cycle level > 0: pop the entry and drive it on sample_out. On read_req with pre-cycle level == 0: drive SILENCE, increment underflow_cnt, and go to FILL.
- Write rule: sample_valid with pre-cycle level < DEPTH stores sample_in and advances wr_ptr. With pre-cycle level == DEPTH the sample is dropped, overflow_cnt increments, and pointers are unchanged.
- Full/empty decisions always use the pre-cycle level; there is no write-through.
  - Write and read in the same cycle while full in PLAY: both succeed and level is unchanged.
  - Write and read in the same cycle while empty in PLAY: the read underflows (SILENCE), the write is stored, level becomes 1, and the state goes to FILL.
- level update per cycle: +1 on an accepted write, -1 on an accepted pop, net 0 when both occur.
- Counters saturate at 255 and never wrap. Two events of the same kind cannot occur in one cycle.
- flush:
  - Effect: wr_ptr, rd_ptr and level go to 0 and the state goes to FILL. sample_out ← SILENCE and out_valid = 0. Counters are unchanged.
  - Priority: flush wins over sample_valid and read_req in the same cycle; both are ignored.
- reset: all of flush, plus overflow_cnt = underflow_cnt = 0. Array contents are don't-care.

## Timing
- Reset values: sample_out = SILENCE, out_valid = 0, level = 0, playing = 0, overflow_cnt = 0, underflow_cnt = 0.
- read_req at cycle N gives sample_out and out_valid=1 at N+1. sample_out holds its value until the next read_req.
- Write latency: a sample_valid at cycle N is poppable by a read_req at N+1 or later.
- playing rises one cycle after the write that reaches PREFILL. It falls one cycle after the underflowing read.
- level reflects all updates from the previous edge (registered).
- Reset or flush asserted mid-playback takes effect on the same edge. An in-flight out_valid is suppressed.

## Structure
- team_06_pkg gets:
  - typedef sample_t (logic signed [7:0]);
  - enum fifo_state_t {FILL, PLAY};
  - localparam SAT_MAX = 8'd255.
- One sub-module, team_06_sat_counter (8-bit, inc/clear inputs, saturating), instantiated twice for the overflow and underflow counters.
- Storage, pointers and the state machine stay in the top of this block. No vendor RAM macro.

## Test plan
- Prefill: reset, then 7 writes (0x01 to 0x07). Check playing=0, and that read_req returns 0x00 with underflow_cnt=0. The 8th write gives playing=1 next cycle; four reads then return 0x01 to 0x04 in order, each 1 cycle after read_req.
- Underflow: in PLAY with level=1, two reads return the stored value, then 0x00. Check underflow_cnt=1 and playing=0 a cycle later.
- Overflow: 20 writes in FILL with no reads. Check level=16 and overflow_cnt=4. Reads then return the first 16 values; values 17 to 20 are never output.
- Simultaneous: with level=16 in PLAY, pulse write and read together. Check level stays 16 and the oldest sample is output. With level=0 in PLAY, the same gives sample_out=0x00, level=1, state FILL.
- Wrap-around: stream 100 samples with interleaved reads keeping level between 4 and 12. Output must equal the input sequence exactly, with no underflow or overflow counts.
- Flush/saturation: flush mid-PLAY gives level=0, playing=0 and counters unchanged. Force 300 overflows and check overflow_cnt=255. Reset clears the counters.
